// File: rtl/cpu_dp.sv
// ---------------------------------------------------------------------------
// cpu_dp : execution datapath that sits after the microprogrammed control unit.
//
// It holds a register file of R0..R7 plus a temp register R8, the ALU and
// shifter, and the registered status word (psw) that the control unit
// branches on. It also drives the data-memory address, the write data and
// the write strobe.
//
// Parameter
//   bw      data/register width (bw >= 4)
//
// Ports
//   clk     system clock; all state changes on the rising edge
//   rst     asynchronous active-low reset; clears R0..R8 and psw
//   cw      control word: [12:9] FS, [8] MB, [7] MD, [6] RW, [5] MW,
//           [4] FL, [3] TD, [2] TA, [1] TB, [0] MA
//   ir_ops  operand fields: [8:6] DA, [5:3] AA, [2:0] BA
//   pc      current program counter (addr when MA=0)
//   din     memory read data
//   psw     registered flags {z, n, c, v}
//   addr    memory address (MA ? A bus : pc)
//   dout    memory write data (the B bus)
//   mw      memory write enable (cw[5], combinational)
//
// Optional feature: define CPU_DP_MUL_EN to turn FS=1111 into an unsigned
// multiply (low bw bits of A*B). When the macro is undefined, FS=1111
// gives a zero result.
// ---------------------------------------------------------------------------
module cpu_dp #(
   parameter int bw = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [12:0]   cw,
   input  logic [8:0]    ir_ops,
   input  logic [8:0]    pc,
   input  logic [bw-1:0] din,
   output logic [3:0]    psw,
   output logic [8:0]    addr,
   output logic [bw-1:0] dout,
   output logic          mw
);

   // control word fields
   logic [3:0] fs;
   logic       mb, md, rw, fl, td, ta, tb, ma;

   assign fs = cw[12:9];
   assign mb = cw[8];
   assign md = cw[7];
   assign rw = cw[6];
   assign mw = cw[5];
   assign fl = cw[4];
   assign td = cw[3];
   assign ta = cw[2];
   assign tb = cw[1];
   assign ma = cw[0];

   // Register file: entry 8 is the temp register. The TA, TB and TD
   // selects are folded into 4-bit indexes, so that one array serves
   // all three ports.
   logic [bw-1:0] rf [0:8];
   logic [3:0]    a_idx, b_idx, d_idx;

   assign a_idx = ta ? 4'd8 : {1'b0, ir_ops[5:3]};
   assign b_idx = tb ? 4'd8 : {1'b0, ir_ops[2:0]};
   assign d_idx = td ? 4'd8 : {1'b0, ir_ops[8:6]};

   logic [bw-1:0] a_bus, b_src, b_bus, d_bus;

   assign a_bus = rf[a_idx];
   assign b_src = rf[b_idx];
   assign b_bus = mb ? {{(bw-3){1'b0}}, ir_ops[2:0]} : b_src;
   assign dout  = b_bus;

   // The A bus is fitted to the 9-bit address: zero-extended when it is
   // narrower, truncated when it is wider.
   logic [8:0] a_addr;

   if (bw >= 9) begin : g_addr_trunc
      assign a_addr = a_bus[8:0];
   end else begin : g_addr_ext
      assign a_addr = {{(9-bw){1'b0}}, a_bus};
   end

   assign addr = ma ? a_addr : pc;

   // Adder operand selection. Every arithmetic code (0001..0110) becomes
   // A + y + cin in bw+1 bits, so that carry and overflow come from a
   // single adder. A-1 is A + all-ones, which leaves c=0 exactly when A
   // was zero (a borrow).
   logic [bw-1:0] add_y;
   logic          add_cin;
   logic [bw:0]   sum;
   logic          add_v;

   // NOTE: every signal written in an always_comb gets a default first, so
   // that no path leaves it unassigned and no latch is inferred.
   always_comb begin
      add_y   = '0;
      add_cin = 1'b0;
      case (fs)
         4'b0001: add_cin = 1'b1;
         4'b0010: add_y   = b_bus;
         4'b0011: begin
            add_y   = b_bus;
            add_cin = psw[1];
         end
         4'b0100: add_y = ~b_bus;
         4'b0101: begin
            add_y   = ~b_bus;
            add_cin = 1'b1;
         end
         4'b0110: add_y = '1;
         default: ;
      endcase
   end

   assign sum   = {1'b0, a_bus} + {1'b0, add_y} + {{bw{1'b0}}, add_cin};
   // Signed overflow: the operands have the same sign, and the sign of
   // the sum differs from it.
   assign add_v = (a_bus[bw-1] == add_y[bw-1]) && (sum[bw-1] != a_bus[bw-1]);

`ifdef CPU_DP_MUL_EN
   logic [2*bw-1:0] prod;
   assign prod = {{bw{1'b0}}, a_bus} * {{bw{1'b0}}, b_bus};
`endif

   // Result and flag selection
   logic [bw-1:0] res;
   logic          c_f, v_f;

   always_comb begin
      res = '0;
      c_f = 1'b0;
      v_f = 1'b0;
      case (fs)
         4'b0000: res = a_bus;
         4'b0111: res = b_bus;
         4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
            res = sum[bw-1:0];
            c_f = sum[bw];
            v_f = add_v;
         end
         4'b1000: res = a_bus & b_bus;
         4'b1001: res = a_bus | b_bus;
         4'b1010: res = a_bus ^ b_bus;
         4'b1011: res = ~a_bus;
         4'b1100: begin
            res = {1'b0, b_bus[bw-1:1]};
            c_f = b_bus[0];
         end
         4'b1101: begin
            res = {b_bus[bw-2:0], 1'b0};
            c_f = b_bus[bw-1];
         end
         4'b1110: begin
            res = {b_bus[bw-1], b_bus[bw-1:1]};
            c_f = b_bus[0];
         end
         default: begin
`ifdef CPU_DP_MUL_EN
            res = prod[bw-1:0];
            c_f = |prod[2*bw-1:bw];
`else
            res = '0;
`endif
         end
      endcase
   end

   // z and n always come from the ALU result, even when the D bus
   // carries din.
   logic z_f, n_f;

   assign z_f   = (res == '0);
   assign n_f   = res[bw-1];
   assign d_bus = md ? din : res;

   // NOTE: the register file is small and must read as zero after reset,
   // so the whole array sits on the async reset, not just the psw.
   // NOTE: state is updated with non-blocking assignments. Reads in the
   // same cycle therefore see the old value, and there is no forwarding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) rf[i] <= '0;
         psw <= 4'b0000;
      end else begin
         if (rw) rf[d_idx] <= d_bus;
         if (fl) psw <= {z_f, n_f, c_f, v_f};
      end
   end

endmodule

// File: tb/tb_cpu_dp.sv
// ---------------------------------------------------------------------------
// tb_cpu_dp : self-checking bench for cpu_dp (bw = 8).
// Each record in the vector table drives one cycle. The expected bus values
// and the psw value after the edge are queued when the record is driven.
// They are popped and compared when the DUT shows them: addr, dout and mw
// on the falling edge, and psw just after the following rising edge.
// Reset hold and the mid-cycle reset are written out as separate sequences.
// ---------------------------------------------------------------------------
module tb_cpu_dp;

   logic        clk;
   logic        rst;
   logic [12:0] cw;
   logic [8:0]  ir_ops;
   logic [8:0]  pc;
   logic [7:0]  din;
   logic [3:0]  psw;
   logic [8:0]  addr;
   logic [7:0]  dout;
   logic        mw;

   cpu_dp #(.bw(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .cw     (cw),
      .ir_ops (ir_ops),
      .pc     (pc),
      .din    (din),
      .psw    (psw),
      .addr   (addr),
      .dout   (dout),
      .mw     (mw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [12:0] cw;
      logic [8:0]  ops;
      logic [7:0]  din;
      logic [8:0]  pc;
      logic [8:0]  e_addr;
      logic [7:0]  e_dout;
      logic        e_mw;
      logic [3:0]  e_psw;
   } vec_t;

   vec_t vt[$];
   vec_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

`ifdef CPU_DP_MUL_EN
   localparam logic [3:0] MUL_PSW = 4'b1010;
`else
   localparam logic [3:0] MUL_PSW = 4'b1000;
`endif

   function automatic logic [12:0] cwf(input logic [3:0] fs, input logic mb, input logic md,
                                       input logic rw, input logic mw_b, input logic fl,
                                       input logic td, input logic ta, input logic tb,
                                       input logic ma);
      return {fs, mb, md, rw, mw_b, fl, td, ta, tb, ma};
   endfunction

   function automatic vec_t mk(input string name, input logic [12:0] c, input logic [2:0] da,
                               input logic [2:0] aa, input logic [2:0] ba, input logic [7:0] d,
                               input logic [8:0] p, input logic [8:0] ea, input logic [7:0] ed,
                               input logic emw, input logic [3:0] ep);
      vec_t v;
      v.name = name; v.cw = c; v.ops = {da, aa, ba}; v.din = d; v.pc = p;
      v.e_addr = ea; v.e_dout = ed; v.e_mw = emw; v.e_psw = ep;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic apply(input vec_t v);
      vec_t e;
      cw = v.cw; ir_ops = v.ops; din = v.din; pc = v.pc;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      check({e.name, "_addr"}, {7'd0, addr}, {7'd0, e.e_addr});
      check({e.name, "_dout"}, {8'd0, dout}, {8'd0, e.e_dout});
      check({e.name, "_mw"},   {15'd0, mw},  {15'd0, e.e_mw});
      @(posedge clk);
      #1;
      check({e.name, "_psw"},  {12'd0, psw}, {12'd0, e.e_psw});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Vector table:
      // name, cw(fs,mb,md,rw,mw,fl,td,ta,tb,ma), da, aa, ba, din, pc,
      // exp addr, exp dout, exp mw, exp psw after the edge
      vt.push_back(mk("ld_r1_7f",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 1,0,0, 8'h7F, 9'h010, 9'h010, 8'h00, 0, 4'b0000));
      vt.push_back(mk("ld_r2_01",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 2,0,0, 8'h01, 9'h011, 9'h011, 8'h00, 0, 4'b0000));
      vt.push_back(mk("add_ovf",   cwf(4'b0010,0,0,1,0,1,0,0,0,0), 3,1,2, 8'h00, 9'h012, 9'h012, 8'h01, 0, 4'b0101));
      vt.push_back(mk("rd_r3_ma",  cwf(4'b0000,0,0,0,0,1,0,0,0,1), 0,3,1, 8'h00, 9'h013, 9'h080, 8'h7F, 0, 4'b0100));
      vt.push_back(mk("ld_r1_05",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 1,0,3, 8'h05, 9'h014, 9'h014, 8'h80, 0, 4'b0100));
      vt.push_back(mk("ld_r2_05",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 2,0,1, 8'h05, 9'h015, 9'h015, 8'h05, 0, 4'b0100));
      vt.push_back(mk("sub_eq",    cwf(4'b0101,0,0,0,0,1,0,0,0,0), 0,1,2, 8'h00, 9'h016, 9'h016, 8'h05, 0, 4'b1010));
      vt.push_back(mk("sub_nofl",  cwf(4'b0101,0,0,0,0,0,0,0,0,0), 0,1,2, 8'h00, 9'h017, 9'h017, 8'h05, 0, 4'b1010));
      vt.push_back(mk("add_nofl",  cwf(4'b0010,0,0,0,0,0,0,0,0,0), 0,1,2, 8'h00, 9'h018, 9'h018, 8'h05, 0, 4'b1010));
      vt.push_back(mk("imm_r8",    cwf(4'b0111,1,0,1,0,0,1,0,0,0), 0,0,3, 8'h00, 9'h019, 9'h019, 8'h03, 0, 4'b1010));
      vt.push_back(mk("ta_ma_mw",  cwf(4'b0000,0,0,0,1,0,0,1,0,1), 0,0,1, 8'h00, 9'h01A, 9'h003, 8'h05, 1, 4'b1010));
      vt.push_back(mk("ld_r1_81",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 1,0,1, 8'h81, 9'h01B, 9'h01B, 8'h05, 0, 4'b1010));
      vt.push_back(mk("shr_l",     cwf(4'b1100,0,0,0,0,1,0,0,0,0), 0,0,1, 8'h00, 9'h01C, 9'h01C, 8'h81, 0, 4'b0010));
      vt.push_back(mk("adc",       cwf(4'b0011,0,0,1,0,1,0,0,0,0), 5,0,0, 8'h00, 9'h01D, 9'h01D, 8'h00, 0, 4'b0000));
      vt.push_back(mk("rd_r5",     cwf(4'b0111,0,0,0,0,1,0,0,0,0), 0,0,5, 8'h00, 9'h01E, 9'h01E, 8'h01, 0, 4'b0000));
      vt.push_back(mk("ld_r6_ff",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 6,0,0, 8'hFF, 9'h01F, 9'h01F, 8'h00, 0, 4'b0000));
      vt.push_back(mk("inc_wrap",  cwf(4'b0001,0,0,1,0,1,0,0,0,0), 7,6,6, 8'h00, 9'h020, 9'h020, 8'hFF, 0, 4'b1010));
      vt.push_back(mk("dec_wrap",  cwf(4'b0110,0,0,0,0,1,0,0,0,0), 0,7,6, 8'h00, 9'h021, 9'h021, 8'hFF, 0, 4'b0100));
      vt.push_back(mk("asr",       cwf(4'b1110,0,0,0,0,1,0,0,0,0), 0,0,1, 8'h00, 9'h022, 9'h022, 8'h81, 0, 4'b0110));
      vt.push_back(mk("shl",       cwf(4'b1101,0,0,0,0,1,0,0,0,0), 0,0,1, 8'h00, 9'h023, 9'h023, 8'h81, 0, 4'b0010));
      vt.push_back(mk("xor",       cwf(4'b1010,0,0,0,0,1,0,0,0,0), 0,1,6, 8'h00, 9'h024, 9'h024, 8'hFF, 0, 4'b0000));
      vt.push_back(mk("not",       cwf(4'b1011,0,0,0,0,1,0,0,0,0), 0,0,0, 8'h00, 9'h025, 9'h025, 8'h00, 0, 4'b0100));
      vt.push_back(mk("ld_r4_10",  cwf(4'b0000,0,1,1,0,0,0,0,0,0), 4,0,0, 8'h10, 9'h026, 9'h026, 8'h00, 0, 4'b0100));
      vt.push_back(mk("fs1111",    cwf(4'b1111,0,0,0,0,1,0,0,0,0), 0,4,4, 8'h00, 9'h027, 9'h027, 8'h10, 0, MUL_PSW));
      vt.push_back(mk("and",       cwf(4'b1000,0,0,0,0,1,0,0,0,0), 0,1,6, 8'h00, 9'h028, 9'h028, 8'hFF, 0, 4'b0100));
      vt.push_back(mk("or_imm",    cwf(4'b1001,1,0,0,0,1,0,0,0,0), 0,0,5, 8'h00, 9'h029, 9'h029, 8'h05, 0, 4'b0000));
      vt.push_back(mk("a_plus_nb", cwf(4'b0100,0,0,0,0,1,0,0,0,0), 0,1,1, 8'h00, 9'h02A, 9'h02A, 8'h81, 0, 4'b0100));
      vt.push_back(mk("sub_ovf",   cwf(4'b0101,0,0,0,0,1,0,0,0,0), 0,3,5, 8'h00, 9'h02B, 9'h02B, 8'h01, 0, 4'b0011));
      vt.push_back(mk("md_flags",  cwf(4'b0000,0,1,1,0,1,0,0,0,0), 2,0,0, 8'h55, 9'h02C, 9'h02C, 8'h00, 0, 4'b1000));
      vt.push_back(mk("not_rd_r2", cwf(4'b1011,0,0,0,0,1,0,0,0,0), 0,0,2, 8'h00, 9'h02D, 9'h02D, 8'h55, 0, 4'b0100));

      // Reset hold: a pending write and flag load must not take effect
      // while rst is low.
      rst = 1'b0;
      cw = cwf(4'b1011,0,1,1,0,1,0,0,0,0); ir_ops = {3'd1, 3'd0, 3'd1}; din = 8'hAA; pc = 9'h0A5;
      #1;
      check("rst_psw", {12'd0, psw}, 16'h0000);
      check("rst_addr_pc", {7'd0, addr}, 16'h00A5);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_psw", {12'd0, psw}, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         ir_ops = {3'd1, 3'd0, 3'(i)};
         #1;
         check($sformatf("rst_r%0d", i), {8'd0, dout}, 16'h0000);
      end
      cw = cwf(4'b0000,0,0,0,0,0,0,0,1,0);
      #1;
      check("rst_r8", {8'd0, dout}, 16'h0000);
      cw = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vt[i]) apply(vt[i]);

      // Mid-cycle async reset with RW and FL pending. psw is 0100 and
      // R6=FF going in; the pending op would write 80 into R7.
      cw = cwf(4'b0010,0,0,1,0,1,0,0,0,0); ir_ops = {3'd7, 3'd1, 3'd6}; pc = 9'h1FF;
      #1;
      check("pre_rst_dout", {8'd0, dout}, 16'h00FF);
      check("pre_rst_psw", {12'd0, psw}, 16'h0004);
      #1;
      rst = 1'b0;
      #1;
      check("async_psw", {12'd0, psw}, 16'h0000);
      check("async_r6", {8'd0, dout}, 16'h0000);
      @(posedge clk);
      #1;
      check("async_hold_psw", {12'd0, psw}, 16'h0000);
      cw = '0; ir_ops = {3'd0, 3'd0, 3'd7};
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_no_wr_r7", {8'd0, dout}, 16'h0000);
      @(posedge clk);
      #1;
      apply(mk("post_ld_r7", cwf(4'b0000,0,1,1,0,0,0,0,0,0), 7,0,7, 8'h3C, 9'h030, 9'h030, 8'h00, 0, 4'b0000));
      apply(mk("post_rd_r7", cwf(4'b0111,0,0,0,0,1,0,0,0,0), 0,0,7, 8'h00, 9'h031, 9'h031, 8'h3C, 0, 4'b0000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_dp.md
Name: cpu_dp

Overview:
Execution datapath directly downstream of the microprogrammed control unit. Consumes the 13-bit control word, instruction operand fields and PC from the control unit. Holds an 8+1 entry register file, ALU/shifter and the registered status word (psw) that the control unit branches on. Drives the data-memory address, write data and write strobe.

Parameters:
bw, 8, data/register width (bw >= 4)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
cw  input  13  control word: [12:9] FS, [8] MB, [7] MD, [6] RW, [5] MW, [4] FL, [3] TD, [2] TA, [1] TB, [0] MA
ir_ops  input  9  operand fields: [8:6] DA, [5:3] AA, [2:0] BA
pc  input  9  current program counter
din  input  bw  memory read data
psw  output  4  registered flags {z,n,c,v}
addr  output  9  memory address
dout  output  bw  memory write data (= B bus)
mw  output  1  memory write enable (= cw[5], combinational)

Behaviour:
- Register file: R0..R7 plus temp R8. Two combinational read ports:
  - A bus = TA ? R8 : R[AA]
  - B source = TB ? R8 : R[BA]
  - B bus = MB ? zero-extended BA (constant 0..7) : B source
- D bus = MD ? din : ALU result.
- Write: RW=1 at posedge writes D into (TD ? R8 : R[DA]). Read-during-write returns the old value. No forwarding.
- addr = MA ? A bus zero-extended/truncated to 9 bits : pc.
- ALU FS codes:
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+psw.c
  - 0100 A+~B
  - 0101 A-B (A+~B+1)
  - 0110 A-1
  - 0111 B
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 B>>1 logical
  - 1101 B<<1
  - 1110 B>>1 arithmetic
  - 1111 result 0 (see option)
- Arithmetic (0000-0111) is computed in bw+1 bits.
  - c = bit bw of the sum; for subtract, c=1 means no borrow.
  - v = signed overflow of the effective two's-complement addition.
  - A and B transfers give c=0, v=0.
- Logic ops: c=0, v=0.
- Shifts: c = bit shifted out, v=0.
- z = (result==0), n = result[bw-1]. Flags are computed from the ALU result even when MD=1.
- psw loads only when FL=1 at posedge; otherwise it holds. FL and RW in the same cycle both take effect.
- Wrap-around: A+1 on all-ones gives 0 with z=1, c=1. A-1 on 0 gives all-ones with n=1, c=0.
- Latency: combinational from cw/ir_ops to addr/dout/mw; one clock to register or psw update.
- Reset (rst=0, asynchronous): R0..R8=0, psw=4'b0000. Writes are suppressed while rst=0, regardless of RW/FL. Reset mid-cycle discards the pending write.

Optional Feature:
- Macro CPU_DP_MUL_EN.
- Defined: FS=1111 gives the low bw bits of unsigned A*B (combinational). z/n are set from the result; c=1 if the upper bw bits are nonzero; v=0.
- Undefined: FS=1111 gives result 0 with z=1, n=0, c=0, v=0.

Test Plan:
- Reset: hold rst=0 then release → psw=0000; all registers read 0; addr=pc with MA=0.
- Load and add, through MD=1 writes: din=8'h7F into R1 (DA=1), din=8'h01 into R2. Then FS=0010, AA=1, BA=2, DA=3, RW=1, FL=1 → R3=8'h80, psw z=0 n=1 c=0 v=1.
- Subtract equal: R1=R2=8'h05, FS=0101, FL=1 → result 0, psw z=1 n=0 c=1 v=0. Same values with FL=0 → psw unchanged.
- Immediate/temp: MB=1, BA=3, FS=0111, TD=1, RW=1 → R8=3. Then TA=1, MA=1 → addr=9'h003. MW=1 → mw=1, dout=B bus.
- Shift/carry chain: R1=8'h81, FS=1100 → 8'h40, c=1. Then FS=0011 with A=B=8'h00 → result 1 (uses psw.c).
- Async reset mid-op: assert rst=0 between edges with RW=1, FL=1 pending → registers and psw clear immediately, no write at the next edge. With CPU_DP_MUL_EN: A=8'h10, B=8'h10, FS=1111 → 8'h00, z=1, c=1.
